// File: rtl/rx_bit_timing.sv
// rtl/rx_bit_timing.sv - UART receive bit timing: edge/bit counters and 3-sample majority vote.
module rx_bit_timing #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  edg_cnt_en,
   input  logic                  sampler_en,
   output logic [PRESCALE_W-1:0] edg_cnt,
   output logic [3:0]            bit_cnt,
   output logic                  sampled_bit,
   output logic                  sample_done,
   output logic                  cfg_err
);
   localparam logic [PRESCALE_W-1:0] PRE_8  = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] PRE_16 = PRESCALE_W'(16);
   localparam logic [PRESCALE_W-1:0] PRE_32 = PRESCALE_W'(32);

   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic                  cfg_err_q, cfg_err_d;
   logic [PRESCALE_W-1:0] edg_q, edg_d;
   logic [3:0]            bit_q, bit_d;
   logic                  s0_q, s0_d, s1_q, s1_d;
   logic                  v0_q, v0_d, v1_q, v1_d;
   logic                  smp_q, smp_d;
   logic                  done_q, done_d;

   logic [PRESCALE_W-1:0] half, pt0, pt1, pt2;
   logic                  wrap, cap_ok, cap0, cap1, cap2, vote, pre_legal;

   always_comb begin
      half      = pre_q >> 1;
      pt0       = half - PRESCALE_W'(2);
      pt1       = half - PRESCALE_W'(1);
      pt2       = half;
      wrap      = edg_cnt_en && (edg_q == pre_q - PRESCALE_W'(1));
      cap_ok    = sampler_en && edg_cnt_en;
      cap0      = cap_ok && (edg_q == pt0);
      cap1      = cap_ok && (edg_q == pt1);
      cap2      = cap_ok && (edg_q == pt2);
      // The third sample is voted straight from rx_in so the result lands at half+1.
      vote      = cap2 && v0_q && v1_q;
      pre_legal = (prescale == PRE_8) || (prescale == PRE_16) || (prescale == PRE_32);
   end

   always_comb begin
      pre_d     = pre_q;
      cfg_err_d = cfg_err_q;
      if (!edg_cnt_en) begin
         if (pre_legal) begin
            pre_d     = prescale;
            cfg_err_d = 1'b0;
         end else begin
            pre_d     = PRE_8;
            cfg_err_d = 1'b1;
         end
      end

      edg_d = '0;
      bit_d = '0;
      if (edg_cnt_en) begin
         edg_d = wrap ? '0 : edg_q + PRESCALE_W'(1);
         bit_d = (wrap && bit_q != 4'd15) ? bit_q + 4'd1 : bit_q;
      end

      s0_d = cap0 ? rx_in : s0_q;
      s1_d = cap1 ? rx_in : s1_q;
      v0_d = v0_q | cap0;
      v1_d = v1_q | cap1;
      if (!edg_cnt_en || vote || wrap) begin
         v0_d = 1'b0;
         v1_d = 1'b0;
      end

      smp_d  = vote ? ((s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in)) : smp_q;
      done_d = vote;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_q     <= PRE_8;
         cfg_err_q <= 1'b0;
         edg_q     <= '0;
         bit_q     <= '0;
         s0_q      <= 1'b0;
         s1_q      <= 1'b0;
         v0_q      <= 1'b0;
         v1_q      <= 1'b0;
         smp_q     <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         cfg_err_q <= cfg_err_d;
         edg_q     <= edg_d;
         bit_q     <= bit_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         v0_q      <= v0_d;
         v1_q      <= v1_d;
         smp_q     <= smp_d;
         done_q    <= done_d;
      end
   end

   assign edg_cnt     = edg_q;
   assign bit_cnt     = bit_q;
   assign sampled_bit = smp_q;
   assign sample_done = done_q;
   assign cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_rx_bit_timing.sv
// tb/tb_rx_bit_timing.sv - scoreboard bench for rx_bit_timing.
module tb_rx_bit_timing;
   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst, rx_in, edg_cnt_en, sampler_en;
   logic [W-1:0] prescale;
   logic [W-1:0] edg_cnt;
   logic [3:0]   bit_cnt;
   logic         sampled_bit, sample_done, cfg_err;

   always #5 clk = ~clk;

   rx_bit_timing #(.PRESCALE_W(W)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
      .edg_cnt_en(edg_cnt_en), .sampler_en(sampler_en),
      .edg_cnt(edg_cnt), .bit_cnt(bit_cnt), .sampled_bit(sampled_bit),
      .sample_done(sample_done), .cfg_err(cfg_err)
   );

   typedef struct packed {
      logic         b;
      logic [W-1:0] e;
      logic [3:0]   bc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_x;
   int          total = 0;
   int          bad = 0;

   int          exp_pre;
   logic        exp_cfg;
   logic [31:0] pat;
   logic [31:0] glmask [0:31];
   int          drop_bit, drop_edg, chg_bit;
   logic [W-1:0] chg_val;
   logic        last_exp;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every sample_done pulse must match the oldest expected vote.
   always @(negedge clk) begin
      if (sample_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got sample_done=1 expected none at %0t", $time);
         end else begin
            mon_x = sb_q.pop_front();
            chk("vote_bit", int'(sampled_bit), int'(mon_x.b));
            chk("vote_edg", int'(edg_cnt), int'(mon_x.e));
            chk("vote_bitcnt", int'(bit_cnt), int'(mon_x.bc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rxv(input int b, input int e);
      return pat[b] & ~glmask[b][e];
   endfunction

   task automatic idle(input int p);
      prescale   = W'(p);
      edg_cnt_en = 1'b0;
      sampler_en = 1'b0;
      rx_in      = 1'b1;
      tick();
   endtask

   task automatic run_frame(input int ncyc);
      int   b, e, half;
      logic a0, a1, a2, v;
      exp_t x;
      half = exp_pre / 2;
      for (int n = 0; n <= ncyc; n++) begin
         b = n / exp_pre;
         e = n % exp_pre;
         chk("edg_cnt", int'(edg_cnt), e);
         chk("bit_cnt", int'(bit_cnt), (b > 15) ? 15 : b);
         chk("cfg_err", int'(cfg_err), int'(exp_cfg));
         if (b == drop_bit && e == half + 1)
            chk("hold_bit", int'(sampled_bit), int'(last_exp));
         if (n == ncyc) begin
            edg_cnt_en = 1'b0;
            sampler_en = 1'b0;
            rx_in      = 1'b1;
         end else begin
            edg_cnt_en = 1'b1;
            sampler_en = !(b == drop_bit && e >= drop_edg);
            rx_in      = rxv(b, e);
            if (chg_bit >= 0 && b >= chg_bit) prescale = chg_val;
            if (b != drop_bit && e == 0 && n + half < ncyc) begin
               a0 = rxv(b, half - 2);
               a1 = rxv(b, half - 1);
               a2 = rxv(b, half);
               v  = (a0 & a1) | (a0 & a2) | (a1 & a2);
               last_exp = v;
               x.b  = v;
               x.e  = W'(half + 1);
               x.bc = 4'((b > 15) ? 15 : b);
               sb_q.push_back(x);
            end
         end
         tick();
      end
      chk("edg_clr", int'(edg_cnt), 0);
      chk("bit_clr", int'(bit_cnt), 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) glmask[i] = '0;
      drop_bit = -1;
      drop_edg = 0;
      chg_bit  = -1;
      chg_val  = '0;
      last_exp = 1'b1;
      exp_cfg  = 1'b0;
      exp_pre  = 8;
      pat      = '0;

      // Reset with hostile inputs.
      rst = 1'b0; rx_in = 1'b0; edg_cnt_en = 1'b1; sampler_en = 1'b1; prescale = W'(8);
      tick();
      tick();
      chk("rst_edg", int'(edg_cnt), 0);
      chk("rst_bit", int'(bit_cnt), 0);
      chk("rst_smp", int'(sampled_bit), 1);
      chk("rst_done", int'(sample_done), 0);
      chk("rst_cfg", int'(cfg_err), 0);
      rst = 1'b1;
      tick();
      chk("rel_edg", int'(edg_cnt), 1);
      idle(8);
      chk("idle_edg", int'(edg_cnt), 0);

      // Prescale 8 frame, pattern 0,1,0,1,1,0,0,1,0,1.
      pat = 32'b1010011010;
      exp_pre = 8;
      run_frame(80);

      // Prescale 16 with glitches; prescale input changes to 8 at bit 3.
      idle(16);
      pat = 32'b01011;
      glmask[0] = 32'h0000_0080;
      glmask[1] = 32'h0000_00C0;
      exp_pre = 16;
      chg_bit = 3;
      chg_val = W'(8);
      run_frame(80);
      chg_bit = -1;
      glmask[0] = '0;
      glmask[1] = '0;

      // Next frame picks up the new prescale of 8.
      idle(8);
      pat = 32'b10;
      exp_pre = 8;
      run_frame(16);

      // Illegal prescale falls back to 8; 32 clears the error.
      idle(12);
      exp_cfg = 1'b1;
      chk("cfg_err_set", int'(cfg_err), 1);
      pat = 32'b101;
      exp_pre = 8;
      run_frame(24);
      idle(32);
      exp_cfg = 1'b0;
      chk("cfg_err_clr", int'(cfg_err), 0);
      pat = 32'b10;
      exp_pre = 32;
      run_frame(49);

      // Saturation over 20 bits, sampler dropped mid bit 17.
      idle(8);
      pat = 32'h0001_6B4D;
      exp_pre = 8;
      drop_bit = 17;
      drop_edg = 3;
      run_frame(160);
      drop_bit = -1;

      idle(8);
      tick();
      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
